// File: rtl/slow2fast_sync.sv
// Brings a slow, asynchronous level into the clk domain and reports its edges.
// Latency: sig2 follows sig1 after SYNC_STAGES edges; pulses one edge later; edge_cnt one edge after that.
// Backpressure: none; the source must hold each sig1 level for at least SYNC_STAGES+1 cycles.
module slow2fast_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sig1,
    output logic        sig2,
    output logic        rise_pulse,
    output logic        fall_pulse,
    output logic        edge_pulse,
    output logic [15:0] edge_cnt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Plain flop-to-flop chain: nothing may sit between sig1 and sync_q[0] or between stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig1};
        end
    end

    assign sig2 = sync_q[SYNC_STAGES-1];

    // hist_q resets to the same level as the chain so reset release never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q     <= RESET_VAL;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            edge_cnt   <= 16'h0000;
        end else begin
            hist_q     <= sig2;
            rise_pulse <= sig2 & ~hist_q;
            fall_pulse <= ~sig2 & hist_q;
            edge_cnt   <= edge_cnt + {15'd0, edge_pulse};
        end
    end

    assign edge_pulse = rise_pulse | fall_pulse;

endmodule

// File: tb/tb_slow2fast_sync.sv
// Directed bench for slow2fast_sync; a second instance covers SYNC_STAGES=3.
module tb_slow2fast_sync;

    logic        clk;
    logic        rst;
    logic        sig1;
    logic        sig2, rise_pulse, fall_pulse, edge_pulse;
    logic [15:0] edge_cnt;
    logic        sig2_3, rise_3, fall_3, edge_3;
    logic [15:0] cnt_3;

    int total = 0;
    int bad   = 0;

    slow2fast_sync dut (
        .clk        (clk),
        .rst        (rst),
        .sig1       (sig1),
        .sig2       (sig2),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .edge_pulse (edge_pulse),
        .edge_cnt   (edge_cnt)
    );

    slow2fast_sync #(.SYNC_STAGES(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .sig1       (sig1),
        .sig2       (sig2_3),
        .rise_pulse (rise_3),
        .fall_pulse (fall_3),
        .edge_pulse (edge_3),
        .edge_cnt   (cnt_3)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic v);
        rst  = 1'b1;
        sig1 = v;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic exp_sig2, exp_rise;
        logic [15:0] exp_cnt;
        rst  = 1'b1;
        sig1 = 1'b1;
        step();
        step();
        total++;
        if (sig2 !== 1'b0 || edge_cnt !== 16'h0 || rise_pulse !== 1'b0 || fall_pulse !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: sig2=%b cnt=%0h rise=%b fall=%b want 0 0 0 0",
                     sig2, edge_cnt, rise_pulse, fall_pulse);
        end
        total++;
        if (sig2_3 !== 1'b0 || cnt_3 !== 16'h0 || rise_3 !== 1'b0 || fall_3 !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold3: sig2=%b cnt=%0h rise=%b fall=%b want 0 0 0 0",
                     sig2_3, cnt_3, rise_3, fall_3);
        end
        rst = 1'b0;
        for (int s = 1; s <= 6; s++) begin
            step();
            exp_sig2 = (s >= 2);
            exp_rise = (s == 3);
            exp_cnt  = (s >= 4) ? 16'd1 : 16'd0;
            total++;
            if (sig2 !== exp_sig2 || rise_pulse !== exp_rise || fall_pulse !== 1'b0 || edge_cnt !== exp_cnt) begin
                bad++;
                $display("FAIL release_s%0d: sig2=%b rise=%b fall=%b cnt=%0h want %b %b 0 %0h",
                         s, sig2, rise_pulse, fall_pulse, edge_cnt, exp_sig2, exp_rise, exp_cnt);
            end
            exp_sig2 = (s >= 3);
            exp_rise = (s == 4);
            exp_cnt  = (s >= 5) ? 16'd1 : 16'd0;
            total++;
            if (sig2_3 !== exp_sig2 || rise_3 !== exp_rise || fall_3 !== 1'b0 || cnt_3 !== exp_cnt) begin
                bad++;
                $display("FAIL release3_s%0d: sig2=%b rise=%b fall=%b cnt=%0h want %b %b 0 %0h",
                         s, sig2_3, rise_3, fall_3, cnt_3, exp_sig2, exp_rise, exp_cnt);
            end
        end
    endtask

    task automatic test_slow_toggle();
        logic v, prev_v;
        int r, f, e;
        do_reset(1'b0);
        repeat (4) step();
        prev_v = 1'b0;
        r = 0;
        f = 0;
        e = 0;
        for (int n = 0; n < 26; n++) begin
            v    = (n < 20) ? ~n[1] : 1'b0;
            sig1 = v;
            step();
            total++;
            if (sig2 !== prev_v) begin
                bad++;
                $display("FAIL slow_wave_n%0d: sig2=%b want %b", n, sig2, prev_v);
            end
            total++;
            if (rise_pulse === 1'b1 && fall_pulse === 1'b1) begin
                bad++;
                $display("FAIL slow_overlap_n%0d: rise=1 fall=1 want not both", n);
            end
            prev_v = v;
            r += int'(rise_pulse === 1'b1);
            f += int'(fall_pulse === 1'b1);
            e += int'(edge_pulse === 1'b1);
        end
        total++;
        if (r != 5 || f != 5 || e != 10) begin
            bad++;
            $display("FAIL slow_pulses: rise=%0d fall=%0d edge=%0d want 5 5 10", r, f, e);
        end
        total++;
        if (edge_cnt !== 16'd10) begin
            bad++;
            $display("FAIL slow_cnt: cnt=%0d want 10", edge_cnt);
        end
    endtask

    task automatic test_short_pulse();
        int hi, r, f;
        do_reset(1'b0);
        repeat (3) step();
        hi = 0;
        r = 0;
        f = 0;
        sig1 = 1'b1;
        for (int n = 0; n < 12; n++) begin
            if (n == 3) sig1 = 1'b0;
            step();
            hi += int'(sig2 === 1'b1);
            r  += int'(rise_pulse === 1'b1);
            f  += int'(fall_pulse === 1'b1);
            if (n == 2) begin
                total++;
                if (rise_pulse !== 1'b1) begin
                    bad++;
                    $display("FAIL short_rise_time: rise=%b want 1", rise_pulse);
                end
            end
            if (n == 5) begin
                total++;
                if (fall_pulse !== 1'b1) begin
                    bad++;
                    $display("FAIL short_fall_time: fall=%b want 1", fall_pulse);
                end
            end
            total++;
            if (rise_pulse === 1'b1 && fall_pulse === 1'b1) begin
                bad++;
                $display("FAIL short_overlap_n%0d: rise=1 fall=1 want not both", n);
            end
        end
        total++;
        if (hi != 3 || r != 1 || f != 1 || edge_cnt !== 16'd2) begin
            bad++;
            $display("FAIL short_summary: high=%0d rise=%0d fall=%0d cnt=%0d want 3 1 1 2",
                     hi, r, f, edge_cnt);
        end
    endtask

    task automatic test_wrap();
        do_reset(1'b0);
        repeat (3) step();
        force dut.edge_cnt = 16'hFFFE;
        step();
        release dut.edge_cnt;
        total++;
        if (edge_cnt !== 16'hFFFE) begin
            bad++;
            $display("FAIL wrap_preload: cnt=%0h want fffe", edge_cnt);
        end
        sig1 = 1'b1;
        repeat (3) step();
        total++;
        if (edge_cnt !== 16'hFFFE) begin
            bad++;
            $display("FAIL wrap_before_rise: cnt=%0h want fffe", edge_cnt);
        end
        step();
        total++;
        if (edge_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL wrap_ffff: cnt=%0h want ffff", edge_cnt);
        end
        sig1 = 1'b0;
        repeat (3) step();
        total++;
        if (edge_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL wrap_before_fall: cnt=%0h want ffff", edge_cnt);
        end
        step();
        total++;
        if (edge_cnt !== 16'h0000) begin
            bad++;
            $display("FAIL wrap_zero: cnt=%0h want 0", edge_cnt);
        end
    endtask

    task automatic test_mid_reset();
        do_reset(1'b0);
        repeat (3) step();
        sig1 = 1'b1;
        repeat (5) step();
        sig1 = 1'b0;
        repeat (5) step();
        total++;
        if (edge_cnt !== 16'd2 || sig2 !== 1'b0) begin
            bad++;
            $display("FAIL mid_setup: cnt=%0d sig2=%b want 2 0", edge_cnt, sig2);
        end
        // Change enters the chain on this edge, reset hits on the next.
        sig1 = 1'b1;
        step();
        rst = 1'b1;
        step();
        total++;
        if (sig2 !== 1'b0 || edge_cnt !== 16'd0 || rise_pulse !== 1'b0 || fall_pulse !== 1'b0) begin
            bad++;
            $display("FAIL mid_flush: sig2=%b cnt=%0d rise=%b fall=%b want 0 0 0 0",
                     sig2, edge_cnt, rise_pulse, fall_pulse);
        end
        rst = 1'b0;
        step();
        step();
        total++;
        if (sig2 !== 1'b1) begin
            bad++;
            $display("FAIL mid_refollow: sig2=%b want 1", sig2);
        end
        rst = 1'b1;
        step();
        total++;
        if (rise_pulse !== 1'b0 || sig2 !== 1'b0 || edge_cnt !== 16'd0) begin
            bad++;
            $display("FAIL mid_pending_pulse: rise=%b sig2=%b cnt=%0d want 0 0 0",
                     rise_pulse, sig2, edge_cnt);
        end
        rst  = 1'b0;
        sig1 = 1'b0;
        step();
    endtask

    initial begin
        rst  = 1'b1;
        sig1 = 1'b0;
        test_reset();
        test_slow_toggle();
        test_short_pulse();
        test_wrap();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slow2fast_sync.md
SLOW2FAST_SYNC -- requirements
Module: slow2fast_sync

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops (legal 2..4).
REQ-002 The block SHALL have parameter RESET_VAL, default 1'b0, giving the reset level of the synchronizer chain and sig2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single (fast) destination clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port sig1, input, 1 bit: level signal from a slower, asynchronous source domain.
REQ-006 The block SHALL have port sig2, output, 1 bit: sig1 synchronized into the clk domain.
REQ-007 The block SHALL have port rise_pulse, output, 1 bit: one-cycle pulse on a 0->1 change of sig2.
REQ-008 The block SHALL have port fall_pulse, output, 1 bit: one-cycle pulse on a 1->0 change of sig2.
REQ-009 The block SHALL have port edge_pulse, output, 1 bit: OR of rise_pulse and fall_pulse.
REQ-010 The block SHALL have port edge_cnt, output, 16 bits: count of edges detected on sig2 since reset.

Function
REQ-011 sig1 SHALL be sampled by a chain of SYNC_STAGES flops; no combinational logic SHALL sit between sig1 and the first flop or between chain flops.
REQ-012 sig2 SHALL be the output of the last chain flop, registered.
REQ-013 Latency: a sig1 level present at clk edge k SHALL appear on sig2 after edge k+SYNC_STAGES-1, i.e. SYNC_STAGES cycles of sampling (2 for the default).
REQ-014 A history flop SHALL hold the previous sig2; rise_pulse = sig2 & ~hist and fall_pulse = ~sig2 & hist, both registered so they assert in the cycle after the sig2 change.
REQ-015 Each pulse SHALL be exactly one clk cycle wide per sig2 transition; rise_pulse and fall_pulse SHALL never be high together.
REQ-016 edge_cnt SHALL increment by 1 in the cycle edge_pulse is high and SHALL wrap from 16'hFFFF to 16'h0000.
REQ-017 The source is required to hold each sig1 level for at least SYNC_STAGES+1 clk cycles; a shorter sig1 pulse MAY be lost, but sig2 SHALL never show a glitch shorter than one clk cycle.
REQ-018 When sig1 is held constant, all outputs other than sig2 SHALL settle and the pulses SHALL stay 0.

Reset
REQ-019 While rst=1 at a clk edge, all chain flops, sig2 and the history flop SHALL load RESET_VAL, the pulses SHALL load 0 and edge_cnt SHALL load 0.
REQ-020 No pulse SHALL be produced by reset itself or by reset release.
REQ-021 After release, if sig1 differs from RESET_VAL, sig2 SHALL follow after SYNC_STAGES cycles and the matching pulse SHALL fire once.
REQ-022 Reset asserted mid-operation SHALL discard in-flight chain contents and override any pending pulse or count increment in the same cycle.

Verification
REQ-023 rst=1 for 2 cycles, sig1=1 throughout, RESET_VAL=0 -> during reset sig2=0 and edge_cnt=0; after release sig2=1 after 2 cycles, then rise_pulse=1 for 1 cycle, then edge_cnt=1.
REQ-024 Slow source: sig1 toggles every 2 clk cycles for 10 toggles (clk period 20 ns) -> sig2 reproduces the waveform delayed 2 cycles; there are 5 rise and 5 fall pulses and edge_cnt=10.
REQ-025 sig1 0->1 held 3 cycles -> sig2 high for exactly 3 cycles; one rise_pulse, one fall_pulse, never simultaneous.
REQ-026 Preload the count near wrap by forcing 65535 edges (or a long toggle run) -> edge_cnt goes 16'hFFFF -> 16'h0000 on the next edge.
REQ-027 Assert rst one cycle after a sig1 change enters the chain -> no pulse fires, sig2=RESET_VAL and edge_cnt=0 on the next cycle.
REQ-028 SYNC_STAGES=3 -> the REQ-023 latency becomes 3 cycles and pulse timing shifts by one cycle.
